// File: rtl/attack_sequencer_if.sv
// rtl/attack_sequencer_if.sv - Player input strobes/levels and sequencer status for one attack_sequencer
interface attack_sequencer_if;
  logic       frame_tick;
  logic       btn_attack;
  logic       btn_left;
  logic       btn_right;
  logic       player_num;
  logic       got_hit;
  logic [2:0] state;
  logic       attacking;
  logic       dir_attacking;
  logic       hit_active;
  logic       busy;

  modport master (
    output frame_tick, btn_attack, btn_left, btn_right, player_num, got_hit,
    input  state, attacking, dir_attacking, hit_active, busy
  );

  modport slave (
    input  frame_tick, btn_attack, btn_left, btn_right, player_num, got_hit,
    output state, attacking, dir_attacking, hit_active, busy
  );
endinterface

// File: rtl/attack_sequencer.sv
// rtl/attack_sequencer.sv - Frame-driven per-player pose/attack sequencer
// Optional ATTACK_BUFFER_EN: a press during RECOVERY chains straight into the next STARTUP.
module attack_sequencer #(
  parameter int BASIC_STARTUP  = 5,
  parameter int BASIC_ACTIVE   = 2,
  parameter int BASIC_RECOVERY = 16,
  parameter int DIR_STARTUP    = 4,
  parameter int DIR_ACTIVE     = 3,
  parameter int DIR_RECOVERY   = 15,
  parameter int HITSTUN_FRAMES = 12,
  parameter int CNT_W          = 5
) (
  input logic              clk,
  input logic              rst,
  attack_sequencer_if.slave io
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FWD      = 3'd1,
    S_BACK     = 3'd2,
    S_HITSTUN  = 3'd3,
    S_STARTUP  = 3'd5,
    S_ACTIVE   = 3'd6,
    S_RECOVERY = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] L_BS  = CNT_W'(BASIC_STARTUP);
  localparam logic [CNT_W-1:0] L_BA  = CNT_W'(BASIC_ACTIVE);
  localparam logic [CNT_W-1:0] L_BR  = CNT_W'(BASIC_RECOVERY);
  localparam logic [CNT_W-1:0] L_DS  = CNT_W'(DIR_STARTUP);
  localparam logic [CNT_W-1:0] L_DA  = CNT_W'(DIR_ACTIVE);
  localparam logic [CNT_W-1:0] L_DR  = CNT_W'(DIR_RECOVERY);
  localparam logic [CNT_W-1:0] L_HS  = CNT_W'(HITSTUN_FRAMES);
  localparam logic [CNT_W-1:0] L_ONE = CNT_W'(1);

  state_t           st, st_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             kind, kind_nx;
  logic             btn_q, atk_pend, dir_pend, hit_pend;
  logic             atk_edge, atk_now, dir_now, hit_now, fwd, back;
  logic             st_attack_nx;

`ifdef ATTACK_BUFFER_EN
  logic buf_pend, buf_dir, rec_edge, buf_now, buf_dir_now, buf_clr;
`endif

  always_comb begin
    atk_edge = io.btn_attack & ~btn_q;
    // An edge on the tick cycle itself is consumed by that same tick.
    atk_now  = atk_pend | atk_edge;
    dir_now  = atk_edge ? (io.btn_left ^ io.btn_right) : dir_pend;
    hit_now  = hit_pend | io.got_hit;
    fwd      = io.player_num ? io.btn_left  : io.btn_right;
    back     = io.player_num ? io.btn_right : io.btn_left;
`ifdef ATTACK_BUFFER_EN
    rec_edge    = atk_edge && (st == S_RECOVERY);
    buf_now     = buf_pend | rec_edge;
    buf_dir_now = rec_edge ? (io.btn_left ^ io.btn_right) : buf_dir;
    buf_clr     = 1'b0;
`endif
    st_nx   = st;
    cnt_nx  = cnt;
    kind_nx = kind;
    if (io.frame_tick) begin
      if (hit_now) begin
        st_nx  = S_HITSTUN;
        cnt_nx = L_HS;
`ifdef ATTACK_BUFFER_EN
        buf_clr = 1'b1;
`endif
      end else begin
        case (st)
          S_IDLE, S_FWD, S_BACK: begin
            if (atk_now) begin
              st_nx   = S_STARTUP;
              kind_nx = dir_now;
              cnt_nx  = dir_now ? L_DS : L_BS;
            end else if (fwd && !back) begin
              st_nx = S_FWD;
            end else if (back && !fwd) begin
              st_nx = S_BACK;
            end else begin
              st_nx = S_IDLE;
            end
          end
          S_STARTUP: begin
            if (cnt == L_ONE) begin
              st_nx  = S_ACTIVE;
              cnt_nx = kind ? L_DA : L_BA;
            end else begin
              cnt_nx = cnt - L_ONE;
            end
          end
          S_ACTIVE: begin
            if (cnt == L_ONE) begin
              st_nx  = S_RECOVERY;
              cnt_nx = kind ? L_DR : L_BR;
            end else begin
              cnt_nx = cnt - L_ONE;
            end
          end
          S_RECOVERY: begin
            if (cnt == L_ONE) begin
`ifdef ATTACK_BUFFER_EN
              if (buf_now) begin
                st_nx   = S_STARTUP;
                kind_nx = buf_dir_now;
                cnt_nx  = buf_dir_now ? L_DS : L_BS;
                buf_clr = 1'b1;
              end else begin
                st_nx  = S_IDLE;
                cnt_nx = '0;
              end
`else
              st_nx  = S_IDLE;
              cnt_nx = '0;
`endif
            end else begin
              cnt_nx = cnt - L_ONE;
            end
          end
          S_HITSTUN: begin
            if (cnt == L_ONE) begin
              st_nx  = S_IDLE;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt - L_ONE;
            end
          end
          default: begin
            st_nx  = S_IDLE;
            cnt_nx = '0;
          end
        endcase
      end
    end
    st_attack_nx = (st_nx == S_STARTUP) || (st_nx == S_ACTIVE) || (st_nx == S_RECOVERY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st       <= S_IDLE;
      cnt      <= '0;
      kind     <= 1'b0;
      btn_q    <= 1'b0;
      atk_pend <= 1'b0;
      dir_pend <= 1'b0;
      hit_pend <= 1'b0;
    end else begin
      st    <= st_nx;
      cnt   <= cnt_nx;
      kind  <= kind_nx;
      btn_q <= io.btn_attack;
      if (io.frame_tick) begin
        atk_pend <= 1'b0;
        dir_pend <= 1'b0;
        hit_pend <= 1'b0;
      end else begin
        if (atk_edge) begin
          atk_pend <= 1'b1;
          dir_pend <= io.btn_left ^ io.btn_right;
        end
        if (io.got_hit) hit_pend <= 1'b1;
      end
    end
  end

`ifdef ATTACK_BUFFER_EN
  // Sticky across ticks; a later press overwrites the buffered direction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_pend <= 1'b0;
      buf_dir  <= 1'b0;
    end else if (buf_clr) begin
      buf_pend <= 1'b0;
    end else if (rec_edge) begin
      buf_pend <= 1'b1;
      buf_dir  <= io.btn_left ^ io.btn_right;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      io.attacking     <= 1'b0;
      io.dir_attacking <= 1'b0;
      io.hit_active    <= 1'b0;
      io.busy          <= 1'b0;
    end else begin
      io.attacking     <= st_attack_nx & ~kind_nx;
      io.dir_attacking <= st_attack_nx & kind_nx;
      io.hit_active    <= (st_nx == S_ACTIVE);
      io.busy          <= st_attack_nx || (st_nx == S_HITSTUN);
    end
  end

  assign io.state = st;

endmodule

// File: tb/tb_attack_sequencer.sv
// tb/tb_attack_sequencer.sv - Scoreboard bench for attack_sequencer (honours ATTACK_BUFFER_EN)
module tb_attack_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  attack_sequencer_if io();
  attack_sequencer dut (.clk(clk), .rst(rst), .io(io));

  logic [6:0] exp_q[$];
  string      name_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  string      cur_name = "reset";

  // Packed view: {state, attacking, dir_attacking, hit_active, busy}
  function automatic logic [6:0] ev(input logic [2:0] s, input logic k);
    logic ph;
    ph = (s == 3'd5) || (s == 3'd6) || (s == 3'd7);
    return {s, ph & ~k, ph & k, s == 3'd6, ph | (s == 3'd3)};
  endfunction

  function automatic logic [6:0] act();
    return {io.state, io.attacking, io.dir_attacking, io.hit_active, io.busy};
  endfunction

  task automatic chk(input string nm, input logic [6:0] a, input logic [6:0] e);
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (io.frame_tick && !rst) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL scoreboard_underflow: got output %b expected none queued", act());
        end else begin
          chk(name_q.pop_front(), act(), exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick(input logic [2:0] s, input logic k);
    exp_q.push_back(ev(s, k));
    name_q.push_back(cur_name);
    io.frame_tick = 1'b1;
    @(posedge clk); #1;
    io.frame_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n, input logic [2:0] s, input logic k);
    repeat (n) tick(s, k);
  endtask

  task automatic press();
    io.btn_attack = 1'b1;
    @(posedge clk); #1;
    io.btn_attack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic hit();
    io.got_hit = 1'b1;
    @(posedge clk); #1;
    io.got_hit = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    io.frame_tick = 1'b0; io.btn_attack = 1'b0; io.btn_left = 1'b0;
    io.btn_right  = 1'b0; io.player_num = 1'b0; io.got_hit  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", act(), 7'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    cur_name = "basic_attack";
    press();
    ticks(5, 3'd5, 1'b0); ticks(2, 3'd6, 1'b0); ticks(16, 3'd7, 1'b0); ticks(3, 3'd0, 1'b0);

    cur_name = "dir_attack_and_moves";
    io.player_num = 1'b1; io.btn_left = 1'b1;
    press();
    ticks(4, 3'd5, 1'b1); ticks(3, 3'd6, 1'b1); ticks(15, 3'd7, 1'b1);
    tick(3'd0, 1'b0);
    tick(3'd1, 1'b0);
    io.btn_left = 1'b0; io.btn_right = 1'b1;
    tick(3'd2, 1'b0);
    io.btn_left = 1'b1;
    tick(3'd0, 1'b0);
    io.btn_left = 1'b0; io.btn_right = 1'b0; io.player_num = 1'b0;
    io.btn_left = 1'b1;
    cur_name = "p0_left_is_back";
    tick(3'd2, 1'b0);
    io.btn_left = 1'b0;
    tick(3'd0, 1'b0);

    cur_name = "interrupted_attack";
    press();
    ticks(5, 3'd5, 1'b0); tick(3'd6, 1'b0);
    hit();
    ticks(12, 3'd3, 1'b0); tick(3'd0, 1'b0);

    cur_name = "double_press";
    press();
    ticks(2, 3'd5, 1'b0);
    press();
    ticks(3, 3'd5, 1'b0); ticks(2, 3'd6, 1'b0); ticks(16, 3'd7, 1'b0); tick(3'd0, 1'b0);

    cur_name = "attack_and_hit_same_frame";
    press();
    hit();
    ticks(12, 3'd3, 1'b0); tick(3'd0, 1'b0);

    cur_name = "hit_reload";
    hit();
    ticks(5, 3'd3, 1'b0);
    hit();
    ticks(12, 3'd3, 1'b0); tick(3'd0, 1'b0);

    cur_name = "edge_on_tick";
    io.btn_attack = 1'b1;
    tick(3'd5, 1'b0);
    io.btn_attack = 1'b0;
    ticks(4, 3'd5, 1'b0); ticks(2, 3'd6, 1'b0); ticks(16, 3'd7, 1'b0); tick(3'd0, 1'b0);

    cur_name = "recovery_press";
    press();
    ticks(5, 3'd5, 1'b0); ticks(2, 3'd6, 1'b0); ticks(3, 3'd7, 1'b0);
    io.btn_left = 1'b1;
    press();
    io.btn_left = 1'b0;
    ticks(13, 3'd7, 1'b0);
`ifdef ATTACK_BUFFER_EN
    ticks(4, 3'd5, 1'b1); ticks(3, 3'd6, 1'b1); ticks(15, 3'd7, 1'b1);
    ticks(2, 3'd0, 1'b0);
`else
    ticks(2, 3'd0, 1'b0);
`endif

    cur_name = "async_reset";
    press();
    ticks(5, 3'd5, 1'b0); ticks(2, 3'd6, 1'b0); ticks(4, 3'd7, 1'b0);
    press();
    #2 rst = 1'b1;
    #1 chk("async_reset_same_cycle", act(), 7'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    cur_name = "no_residual_press";
    ticks(2, 3'd0, 1'b0);

    repeat (5) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
